// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU decode/issue stage.
// Op codes match the execute unit's alu_op port.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        alu_op_e           alu_op;
        logic [XLEN-1:0]   opa;
        logic [XLEN-1:0]   opb;
        logic [4:0]        rd_addr;
        logic              rd_we;
        logic              illegal;
    } ex_bundle_t;

    // funct3 -> ALU op; alt selects SUB/SRA (caller decides whether alt is legal)
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decode_issue_skid_buf.sv
// Output register plus one skid entry between two valid/ready handshakes.
// Ready is registered: it only reflects skid occupancy.
module skid_buf #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    logic r_out_valid;
    logic r_skid_valid;
    T     r_out;
    T     r_skid;

    logic w_in_fire;
    logic w_out_free;

    assign in_ready_o  = !r_skid_valid;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out;

    assign w_in_fire  = in_valid_i && !r_skid_valid;
    assign w_out_free = !r_out_valid || out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (w_out_free) begin
            // Skid is older than anything on the input, so it drains first;
            // input is never accepted while the skid is full.
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_in_fire;
                if (w_in_fire)
                    r_out <= in_data_i;
            end
        end else if (w_in_fire) begin
            r_skid       <= in_data_i;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/alu_decode_issue.sv
// RV32I integer decode (OP, OP-IMM, LUI, AUIPC) feeding the ALU through a
// registered, skid-buffered issue handshake.
module alu_decode_issue
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inst_valid_i,
    output logic            inst_ready_o,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [3:0]      alu_op_o,
    output logic [XLEN-1:0] opa_o,
    output logic [XLEN-1:0] opb_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic            illegal_o
);

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt_r;
    logic [XLEN-1:0] w_shamt_i;
    logic            w_alt;
    ex_bundle_t      w_dec;
    ex_bundle_t      w_out;

    assign w_opc = inst_i[6:0];
    assign w_rd  = inst_i[11:7];
    assign w_f3  = inst_i[14:12];
    assign w_f7  = inst_i[31:25];
    assign w_alt = (w_f7 == F7_ALT);

    assign rs1_addr_o = inst_i[19:15];
    assign rs2_addr_o = inst_i[24:20];

    assign w_imm_i   = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign w_imm_u   = {inst_i[31:12], 12'b0};
    assign w_shamt_r = {{(XLEN-SHAMT_W){1'b0}}, rs2_data_i[SHAMT_W-1:0]};
    assign w_shamt_i = {{(XLEN-SHAMT_W){1'b0}}, inst_i[20 +: SHAMT_W]};

    always_comb begin
        w_dec         = '0;
        w_dec.alu_op  = ALU_ADD;
        w_dec.illegal = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_dec.opa    = rs1_data_i;
                w_dec.opb    = (w_f3 == F3_SLL || w_f3 == F3_SR) ? w_shamt_r : rs2_data_i;
                w_dec.alu_op = f3_to_op(w_f3, w_alt);
                // funct7=0x20 only selects SUB/SRA; M-extension (0x01) and others are rejected
                if (!(w_f7 == F7_BASE || (w_alt && (w_f3 == F3_ADD || w_f3 == F3_SR))))
                    w_dec.illegal = 1'b1;
            end
            OPC_OPIMM: begin
                w_dec.opa = rs1_data_i;
                if (w_f3 == F3_SLL || w_f3 == F3_SR) begin
                    w_dec.opb    = w_shamt_i;
                    w_dec.alu_op = f3_to_op(w_f3, w_alt && (w_f3 == F3_SR));
                    if (!(w_f7 == F7_BASE || (w_alt && w_f3 == F3_SR)))
                        w_dec.illegal = 1'b1;
                end else begin
                    // immediate bits [31:25] are plain immediate here, so no SUBI
                    w_dec.opb    = w_imm_i;
                    w_dec.alu_op = f3_to_op(w_f3, 1'b0);
                end
            end
            OPC_LUI: begin
                w_dec.opa = '0;
                w_dec.opb = w_imm_u;
            end
            OPC_AUIPC: begin
                w_dec.opa = pc_i;
                w_dec.opb = w_imm_u;
            end
            default: w_dec.illegal = 1'b1;
        endcase

        // Illegal instructions still flow in order, but carry a neutral payload
        if (w_dec.illegal) begin
            w_dec.alu_op = ALU_ADD;
            w_dec.opa    = '0;
            w_dec.opb    = '0;
        end
        w_dec.rd_addr = w_rd;
        w_dec.rd_we   = !w_dec.illegal && (w_rd != 5'd0);
    end

    skid_buf #(.T(ex_bundle_t)) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (inst_valid_i),
        .in_ready_o  (inst_ready_o),
        .in_data_i   (w_dec),
        .out_valid_o (ex_valid_o),
        .out_ready_i (ex_ready_i),
        .out_data_o  (w_out)
    );

    assign alu_op_o  = w_out.alu_op;
    assign opa_o     = w_out.opa;
    assign opb_o     = w_out.opb;
    assign rd_addr_o = w_out.rd_addr;
    assign rd_we_o   = w_out.rd_we;
    assign illegal_o = w_out.illegal;

endmodule

// File: tb/tb_alu_decode_issue.sv
// Directed bench for alu_decode_issue: decode vectors, illegal ordering,
// back-pressure through the skid entry and async reset while full.
module tb_alu_decode_issue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        inst_valid_i = 1'b0;
    logic        inst_ready_o;
    logic [31:0] inst_i = '0;
    logic [31:0] pc_i = '0;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic        ex_valid_o;
    logic        ex_ready_i = 1'b1;
    logic [3:0]  alu_op_o;
    logic [31:0] opa_o, opb_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o, illegal_o;

    int checks = 0;
    int errors = 0;

    logic [74:0] got;
    assign got = {alu_op_o, opa_o, opb_o, rd_addr_o, rd_we_o, illegal_o};

    alu_decode_issue #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .inst_i(inst_i), .pc_i(pc_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .alu_op_o(alu_op_o), .opa_o(opa_o), .opb_o(opb_o),
        .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [74:0] mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] rd, input logic we, input logic ill);
        return {op, a, b, rd, we, ill};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    logic [31:0] t_inst[16];
    logic [31:0] t_pc[16];
    logic [31:0] t_a[16];
    logic [31:0] t_b[16];
    logic [74:0] t_exp[16];

    task automatic set_vec(input int i, input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] b, input logic [74:0] e);
        t_inst[i] = inst; t_pc[i] = pc; t_a[i] = a; t_b[i] = b; t_exp[i] = e;
    endtask

    task automatic drive(input int i);
        inst_i = t_inst[i]; pc_i = t_pc[i]; rs1_data_i = t_a[i]; rs2_data_i = t_b[i];
        inst_valid_i = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        checks++;
        if (ex_valid_o !== 1'b0 || got !== 75'd0 || inst_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset: ex_valid=%b bundle=%h ready=%b, want 0/0/1", ex_valid_o, got, inst_ready_o);
        end
        inst_i = enc_r(7'h00, 5'd17, 5'd9, 3'd0, 5'd1, 7'h33);
        #1;
        checks++;
        if (rs1_addr_o !== 5'd9 || rs2_addr_o !== 5'd17) begin
            errors++;
            $display("FAIL rs_addr: rs1=%0d rs2=%0d, want 9/17", rs1_addr_o, rs2_addr_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // one instruction at a time, output slot always drained
    task automatic test_decode;
        set_vec(0,  enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 0, 32'd5, 32'd7, mk(0, 5, 7, 3, 1, 0));
        set_vec(1,  enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33), 0, 32'd10, 32'd3, mk(1, 10, 3, 4, 1, 0));
        set_vec(2,  enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd5, 7'h33), 0, 32'h8000_0000, 32'hFFFF_FFE4,
                mk(9, 32'h8000_0000, 4, 5, 1, 0));
        set_vec(3,  enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd6, 7'h33), 0, 32'd1, 32'hFFFF_FFE3, mk(7, 1, 3, 6, 1, 0));
        set_vec(4,  enc_i(12'h01F, 5'd1, 3'd1, 5'd7, 7'h13), 0, 32'd1, 32'hDEAD, mk(7, 1, 31, 7, 1, 0));
        set_vec(5,  enc_i(12'hFFF, 5'd0, 3'd0, 5'd0, 7'h13), 0, 32'd0, 32'd0, mk(0, 0, 32'hFFFF_FFFF, 0, 0, 0));
        set_vec(6,  {20'hABCDE, 5'd6, 7'h37}, 0, 32'h1234, 32'h5678, mk(0, 0, 32'hABCD_E000, 6, 1, 0));
        set_vec(7,  {20'h00001, 5'd7, 7'h17}, 32'h100, 32'h1234, 32'h0, mk(0, 32'h100, 32'h1000, 7, 1, 0));
        set_vec(8,  enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd8, 7'h33), 0, 32'd3, 32'd9, mk(3, 3, 9, 8, 1, 0));
        set_vec(9,  enc_i(12'h800, 5'd1, 3'd4, 5'd9, 7'h13), 0, 32'hFF, 0, mk(4, 32'hFF, 32'hFFFF_F800, 9, 1, 0));
        set_vec(10, enc_i(12'h404, 5'd1, 3'd5, 5'd10, 7'h13), 0, 32'hF000_0000, 0,
                mk(9, 32'hF000_0000, 4, 10, 1, 0));
        set_vec(11, enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd11, 7'h33), 0, 32'hFFFF_FFFF, 32'd1,
                mk(2, 32'hFFFF_FFFF, 1, 11, 1, 0));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            drive(i);
            @(posedge clk_i);
            #1 inst_valid_i = 1'b0;
            @(negedge clk_i);
            checks++;
            if (ex_valid_o !== 1'b1 || got !== t_exp[i]) begin
                errors++;
                $display("FAIL decode[%0d]: valid=%b bundle=%h, want 1 %h", i, ex_valid_o, got, t_exp[i]);
            end
        end
        @(negedge clk_i);
        checks++;
        if (ex_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain: ex_valid=%b, want 0", ex_valid_o);
        end
    endtask

    // legal and illegal instructions streamed every cycle; order must hold
    task automatic test_back_to_back;
        set_vec(0, enc_i(12'h004, 5'd1, 3'd2, 5'd8, 7'h03), 0, 32'h55, 32'h66, mk(0, 0, 0, 8, 0, 1));
        set_vec(1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd12, 7'h33), 0, 32'd1, 32'd2, mk(0, 1, 2, 12, 1, 0));
        set_vec(2, enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd9, 7'h33), 0, 32'd4, 32'd5, mk(0, 0, 0, 9, 0, 1));
        set_vec(3, enc_i(12'h403, 5'd1, 3'd1, 5'd10, 7'h13), 0, 32'd6, 32'd0, mk(0, 0, 0, 10, 0, 1));
        set_vec(4, enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd13, 7'h33), 0, 32'hF0F0, 32'h0FF0,
                mk(6, 32'hF0F0, 32'h0FF0, 13, 1, 0));
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk_i);
            if (i > 0) begin
                checks++;
                if (ex_valid_o !== 1'b1 || got !== t_exp[i-1]) begin
                    errors++;
                    $display("FAIL b2b[%0d]: valid=%b bundle=%h, want 1 %h", i-1, ex_valid_o, got, t_exp[i-1]);
                end
            end
            if (i < 5) drive(i);
            else inst_valid_i = 1'b0;
        end
    endtask

    // ex_ready low for three edges with four instructions offered
    task automatic test_backpressure;
        int  sent = 0;
        int  recv = 0;
        logic pend_in = 1'b0;
        logic pend_out = 1'b0;
        for (int i = 0; i < 4; i++)
            set_vec(i, enc_i(12'(i + 1), 5'd1, 3'd0, 5'(i + 1), 7'h13), 0, 32'(100 * (i + 1)), 32'hBAD,
                    mk(0, 32'(100 * (i + 1)), 32'(i + 1), 5'(i + 1), 1, 0));
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk_i);
            if (pend_in) sent++;
            if (pend_out) recv++;
            if (ex_valid_o) begin
                checks++;
                if (recv >= 4 || got !== t_exp[recv % 4]) begin
                    errors++;
                    $display("FAIL bp_order cyc%0d: recv=%0d bundle=%h, want %h", cyc, recv, got, t_exp[recv % 4]);
                end
            end
            if (cyc == 2) begin
                checks++;
                if (inst_ready_o !== 1'b0 || ex_valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_full: ready=%b valid=%b, want 0/1", inst_ready_o, ex_valid_o);
                end
            end
            ex_ready_i = (cyc >= 3);
            if (sent < 4) drive(sent);
            else inst_valid_i = 1'b0;
            pend_in  = inst_valid_i & inst_ready_o;
            pend_out = ex_valid_o & ex_ready_i;
        end
        checks++;
        if (sent != 4 || recv != 4 || ex_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: sent=%0d recv=%0d valid=%b, want 4/4/0", sent, recv, ex_valid_o);
        end
    endtask

    task automatic test_async_reset;
        set_vec(0, enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd14, 7'h33), 0, 32'd1, 32'd2, mk(5, 1, 2, 14, 1, 0));
        set_vec(1, enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd15, 7'h33), 0, 32'd3, 32'd4, mk(4, 3, 4, 15, 1, 0));
        ex_ready_i = 1'b0;
        @(negedge clk_i); drive(0);
        @(negedge clk_i); drive(1);
        @(negedge clk_i); inst_valid_i = 1'b0;
        checks++;
        if (inst_ready_o !== 1'b0 || ex_valid_o !== 1'b1 || got !== t_exp[0]) begin
            errors++;
            $display("FAIL pre_rst: ready=%b valid=%b bundle=%h, want 0/1 %h", inst_ready_o, ex_valid_o, got, t_exp[0]);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (ex_valid_o !== 1'b0 || got !== 75'd0) begin
            errors++;
            $display("FAIL async_rst: valid=%b bundle=%h, want 0/0", ex_valid_o, got);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        ex_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (inst_ready_o !== 1'b1 || ex_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL post_rst: ready=%b valid=%b, want 1/0", inst_ready_o, ex_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
